// File: rtl/single_hash_pkg.sv
// Shared arithmetic for the djb2-xor hash step.
// The leaf datapath and the array-level code both call these functions, so
// every instance folds characters in with bit-identical arithmetic.
package single_hash_pkg;

  localparam int HASH_W     = 32;
  localparam int CHAR_W     = 7;
  localparam int HASH_SHIFT = 5;

  typedef logic [HASH_W-1:0] hash_t;
  typedef logic [CHAR_W-1:0] char_t;

  // h * (2^HASH_SHIFT + 1) as a shift-add; carries out of HASH_W are dropped.
  function automatic hash_t hash_mul33(hash_t h);
    return hash_t'((h << HASH_SHIFT) + h);
  endfunction

  // The XOR only reaches the low CHAR_W bits, so the upper bits of a step
  // depend on the seed alone.
  function automatic hash_t hash_step(hash_t seed, char_t chr);
    return hash_mul33(seed) ^ {{(HASH_W-CHAR_W){1'b0}}, chr};
  endfunction

endpackage

// File: rtl/single_hash.sv
// single_hash: one registered step of the djb2-xor string hash,
//   hash_out = (seed * 33) ^ chr, one cycle of latency, no backpressure.
// Optional feature macro: SINGLE_HASH_CMP_EN adds the goal/match partial
// compare ("one more unknown character"), which lands one cycle after
// hash_out.
// The datapath uses the package functions, so WIDTH/CHAR_W/SHIFT must match
// the package constants; a mismatch is rejected at elaboration.
module single_hash
  import single_hash_pkg::*;
#(
  parameter int WIDTH  = single_hash_pkg::HASH_W,
  parameter int CHAR_W = single_hash_pkg::CHAR_W,
  parameter int SHIFT  = single_hash_pkg::HASH_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  seed,
  input  logic [CHAR_W-1:0] chr,
`ifdef SINGLE_HASH_CMP_EN
  input  logic [WIDTH-1:0]  goal,
  output logic              match,
`endif
  output logic              out_valid,
  output logic [WIDTH-1:0]  hash_out
);

  if (WIDTH != single_hash_pkg::HASH_W ||
      CHAR_W != single_hash_pkg::CHAR_W ||
      SHIFT != single_hash_pkg::HASH_SHIFT) begin : g_param_check
    $error("single_hash parameters must match single_hash_pkg constants");
  end

  logic       valid_q, valid_d;
  hash_t      hash_q,  hash_d;

  // Next-state: a valid input loads a new step result, otherwise hold.
  always_comb begin
    valid_d = in_valid;
    hash_d  = hash_q;
    if (in_valid) begin
      hash_d = hash_step(seed, chr);
    end
  end

  // Result register; reset wins over any input and drops in-flight results.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      hash_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hash_q  <= hash_d;
    end
  end

  assign out_valid = valid_q;
  assign hash_out  = hash_q;

`ifdef SINGLE_HASH_CMP_EN
  logic  match_q, match_d;
  hash_t mul_q;

  // Only bits above CHAR_W are compared: the unknown next character can
  // only disturb the low CHAR_W bits of the following step.
  always_comb begin
    mul_q   = hash_mul33(hash_q);
    match_d = valid_q && (mul_q[WIDTH-1:CHAR_W] == goal[WIDTH-1:CHAR_W]);
  end

  // Compare register, one cycle behind hash_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_single_hash.sv
// Directed and random checks for single_hash; the compare checks are built
// only when SINGLE_HASH_CMP_EN is defined.
module tb_single_hash;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] seed;
  logic [6:0]  chr;
  logic        out_valid;
  logic [31:0] hash_out;
`ifdef SINGLE_HASH_CMP_EN
  logic [31:0] goal;
  logic        match;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  single_hash u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .seed      (seed),
    .chr       (chr),
`ifdef SINGLE_HASH_CMP_EN
    .goal      (goal),
    .match     (match),
`endif
    .out_valid (out_valid),
    .hash_out  (hash_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference uses a true multiply, independent of the shift-add in the RTL.
  function automatic logic [31:0] ref_mul33(logic [31:0] s);
    logic [63:0] p;
    p = {32'd0, s} * 64'd33;
    return p[31:0];
  endfunction

  function automatic logic [31:0] ref_step(logic [31:0] s, logic [6:0] c);
    return ref_mul33(s) ^ {25'd0, c};
  endfunction

  // Advance one edge and settle outputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [6:0]  chr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] exp_hash;
    logic        exp_valid;
`ifdef SINGLE_HASH_CMP_EN
    logic        exp_match;
    logic [31:0] rgoal;
    goal = 32'd0;
`endif

    vecs[0] = '{32'h0000_1505, 7'h41, 32'h0002_B5E4};
    vecs[1] = '{32'hFFFF_FFFF, 7'h7F, 32'hFFFF_FFA0};
    vecs[2] = '{32'h8000_0000, 7'h5F, 32'h8000_005F};
    vecs[3] = '{32'h0000_0000, 7'h00, 32'h0000_0000};

    reset = 1'b1; in_valid = 1'b0; seed = '0; chr = '0;
    #1;
    tick(); tick();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_hash", hash_out, 32'd0);
`ifdef SINGLE_HASH_CMP_EN
    check_eq("rst_match", {31'd0, match}, 32'd0);
`endif
    reset = 1'b0;
    tick();
    check_eq("idle_valid", {31'd0, out_valid}, 32'd0);

    // Directed vectors, back to back.
    foreach (vecs[i]) begin
      in_valid = 1'b1; seed = vecs[i].seed; chr = vecs[i].chr;
      tick();
      check_eq($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("vec%0d_hash", i), hash_out, vecs[i].exp);
    end

    // Hold: in_valid low keeps hash_out, drops out_valid.
    in_valid = 1'b1; seed = 32'h0000_1505; chr = 7'h41;
    tick();
    in_valid = 1'b0; seed = 32'hDEAD_BEEF; chr = 7'h12;
    tick();
    check_eq("hold_valid", {31'd0, out_valid}, 32'd0);
    check_eq("hold_hash", hash_out, 32'h0002_B5E4);
    tick();
    check_eq("hold2_hash", hash_out, 32'h0002_B5E4);

    // Reset mid-stream with a valid input presented.
    in_valid = 1'b1; seed = 32'hFFFF_FFFF; chr = 7'h7F;
    tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_hash", hash_out, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("postrst_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; seed = 32'h8000_0000; chr = 7'h5F;
    tick();
    check_eq("postrst_first_valid", {31'd0, out_valid}, 32'd1);
    check_eq("postrst_first_hash", hash_out, 32'h8000_005F);

`ifdef SINGLE_HASH_CMP_EN
    // hash_out=0x0002B5E4, mul33=0x00597264.
    in_valid = 1'b1; seed = 32'h0000_1505; chr = 7'h41; goal = 32'h0059_7200;
    tick();
    check_eq("cmp_hash", hash_out, 32'h0002_B5E4);
    tick();
    check_eq("cmp_match_hit", {31'd0, match}, 32'd1);
    goal = 32'h0059_7280; in_valid = 1'b0;
    tick();
    check_eq("cmp_match_miss", {31'd0, match}, 32'd0);
    goal = 32'h0059_7200;
    tick();
    check_eq("cmp_match_novalid", {31'd0, match}, 32'd0);
`endif

    // Random stream against the reference model.
    exp_hash  = hash_out;
    exp_valid = out_valid;
`ifdef SINGLE_HASH_CMP_EN
    exp_match = match;
`endif
    for (int n = 0; n < 10000; n++) begin
      in_valid = ($urandom_range(0, 9) != 0);
      seed     = $urandom;
      chr      = 7'($urandom_range(0, 127));
`ifdef SINGLE_HASH_CMP_EN
      rgoal = ref_mul33(exp_hash);
      goal  = $urandom_range(0, 1) ? {rgoal[31:7], 7'($urandom_range(0, 127))} : $urandom;
      exp_match = exp_valid && (rgoal[31:7] == goal[31:7]);
`endif
      if (in_valid) exp_hash = ref_step(seed, chr);
      exp_valid = in_valid;
      tick();
      check_eq("rnd_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check_eq("rnd_hash", hash_out, exp_hash);
`ifdef SINGLE_HASH_CMP_EN
      check_eq("rnd_match", {31'd0, match}, {31'd0, exp_match});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
